md6_joystick_reader: RTL and testbench

- Physical-side Mega Drive pad reader.
- Drives the pad select line (pin 7) through the 8-phase 6-button handshake and samples the six active-low data pins.
- Outputs a decoded, active-high 11-bit joystick vector in the same X Z Y START A C B U D L R order consumed by the virtual joystick path.
- Sits between the joystick connector pins and the joystick mux. Detects no pad, 3-button pad or 6-button pad.

---
 rtl/md6_joystick_reader.sv | 146 ++++++++++++++
 tb/tb_md6_joystick_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md6_joystick_reader.sv
// Mega Drive pad reader: walks the pad select line through the 8-phase
// 6-button handshake and decodes the active-low pins into an active-high vector.
module md6_joystick_reader #(
    parameter int STEP_CYCLES = 280,
    parameter int IDLE_CYCLES = 56000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [5:0]  data_in,
    output logic        select_out,
    output logic [10:0] joy_out,
    output logic        pad_present,
    output logic        six_button,
    output logic        scan_done
);

    localparam int CNT_MAX = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    sync1_q, sync1_d;
    logic [5:0]    sync2_q, sync2_d;
    logic          select_q, select_d;
    logic [10:0]   btn_tmp_q, btn_tmp_d;
    logic          present_tmp_q, present_tmp_d;
    logic          six_tmp_q, six_tmp_d;
    logic [10:0]   joy_q, joy_d;
    logic          present_q, present_d;
    logic          six_q, six_d;
    logic          done_q, done_d;
    logic [5:0]    sd;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sync1_d       = data_in;
        sync2_d       = sync1_q;
        btn_tmp_d     = btn_tmp_q;
        present_tmp_d = present_tmp_q;
        six_tmp_d     = six_tmp_q;
        joy_d         = joy_q;
        present_d     = present_q;
        six_d         = six_q;
        done_d        = 1'b0;
        sd            = ~sync2_q;

        if (state_q == IDLE) begin
            if (!enable) begin
                cnt_d = '0;
            end else if (cnt_q == IDLE_LAST) begin
                cnt_d   = '0;
                state_d = PH0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q != STEP_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            // Final cycle of a phase: sample, then advance.
            cnt_d   = '0;
            state_d = (state_q == PH7) ? IDLE : state_t'(state_q + 4'd1);
            case (state_q)
                PH0: begin
                    btn_tmp_d[5] = sd[5];
                    btn_tmp_d[4] = sd[4];
                    btn_tmp_d[0] = sd[3];
                    btn_tmp_d[1] = sd[2];
                    btn_tmp_d[2] = sd[1];
                    btn_tmp_d[3] = sd[0];
                end
                PH1: begin
                    btn_tmp_d[7]  = sd[5];
                    btn_tmp_d[6]  = sd[4];
                    present_tmp_d = (sync2_q[3:2] == 2'b00);
                end
                PH5: six_tmp_d = (sync2_q[3:0] == 4'b0000);
                PH6: begin
                    // MODE on sd[3] is deliberately dropped.
                    btn_tmp_d[10] = six_tmp_q & sd[2];
                    btn_tmp_d[8]  = six_tmp_q & sd[1];
                    btn_tmp_d[9]  = six_tmp_q & sd[0];
                end
                PH7: begin
                    done_d    = 1'b1;
                    present_d = present_tmp_q;
                    six_d     = present_tmp_q & six_tmp_q;
                    if (!present_tmp_q) begin
                        joy_d = '0;
                    end else if (!six_tmp_q) begin
                        joy_d = {3'b000, btn_tmp_q[7:0]};
                    end else begin
                        joy_d = btn_tmp_q;
                    end
                end
                default: ;
            endcase
        end

        select_d = !(state_d inside {PH1, PH3, PH5, PH7});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            select_q      <= 1'b1;
            btn_tmp_q     <= '0;
            present_tmp_q <= 1'b0;
            six_tmp_q     <= 1'b0;
            joy_q         <= '0;
            present_q     <= 1'b0;
            six_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            select_q      <= select_d;
            btn_tmp_q     <= btn_tmp_d;
            present_tmp_q <= present_tmp_d;
            six_tmp_q     <= six_tmp_d;
            joy_q         <= joy_d;
            present_q     <= present_d;
            six_q         <= six_d;
            done_q        <= done_d;
        end
    end

    assign select_out  = select_q;
    assign joy_out     = joy_q;
    assign pad_present = present_q;
    assign six_button  = six_q;
    assign scan_done   = done_q;

endmodule

// File: tb/tb_md6_joystick_reader.sv
// Scoreboard bench: a pad model answers select edges, expectations come from
// the pad type and held buttons, a monitor checks every scan_done.
module tb_md6_joystick_reader;

    localparam int STEP = 8;
    localparam int IDLE = 40;
    localparam int SCAN = IDLE + 8 * STEP;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  data_in;
    logic        select_out;
    logic [10:0] joy_out;
    logic        pad_present;
    logic        six_button;
    logic        scan_done;

    always #5 clk = ~clk;

    md6_joystick_reader #(
        .STEP_CYCLES(STEP),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .select_out (select_out),
        .joy_out    (joy_out),
        .pad_present(pad_present),
        .six_button (six_button),
        .scan_done  (scan_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Pad model. Button vector order: X Z Y START A C B U D L R (bit 10..0).
    int          pad_type = 0;   // 0 none, 1 three-button, 2 six-button
    logic [10:0] btns = '0;
    logic        mode = 1'b0;
    logic        sel_d = 1'b1;
    int          hi_cnt = 0;
    int          edges = 0;

    always @(posedge clk) begin
        sel_d  <= select_out;
        hi_cnt <= select_out ? ((hi_cnt < 1000) ? hi_cnt + 1 : hi_cnt) : 0;
        if (sel_d && !select_out)
            edges <= (edges < 7) ? edges + 1 : edges;
        else if (hi_cnt >= 20)
            edges <= 0;
    end

    always_comb begin
        data_in = 6'h3F;
        if (pad_type != 0) begin
            if (select_out)
                data_in = ~{btns[5], btns[4], btns[0], btns[1], btns[2], btns[3]};
            else
                data_in = {~btns[7], ~btns[6], 2'b00, ~btns[2], ~btns[3]};
            if (pad_type == 2) begin
                if (!select_out && edges == 3)
                    data_in = {~btns[7], ~btns[6], 4'b0000};
                else if (!select_out && edges == 4)
                    data_in = {~btns[7], ~btns[6], 4'b1111};
                else if (select_out && edges == 3)
                    data_in = ~{btns[5], btns[4], mode, btns[10], btns[8], btns[9]};
            end
        end
    end

    // Reference model: what the reader should report for a given pad.
    typedef struct packed {
        logic [10:0] joy;
        logic        pres;
        logic        six;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t expect_for(input int t, input logic [10:0] b);
        exp_t e;
        e = '0;
        if (t == 1) begin
            e.joy  = {3'b000, b[7:0]};
            e.pres = 1'b1;
        end else if (t == 2) begin
            e.joy  = b;
            e.pres = 1'b1;
            e.six  = 1'b1;
        end
        return e;
    endfunction

    task automatic set_pad(input int t, input logic [10:0] b, input logic m);
        logic [10:0] bb;
        bb = b;
        if (bb[3] && bb[2]) bb[2] = 1'b0;   // a real D-pad cannot press up and down
        pad_type = t;
        btns     = bb;
        mode     = m;
    endtask

    task automatic push_exp();
        exp_q.push_back(expect_for(pad_type, btns));
    endtask

    task automatic wait_scan(input int budget, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (scan_done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fall(input int n, input int budget, output bit got);
        int   falls;
        logic prev;
        falls = 0;
        got   = 1'b0;
        prev  = select_out;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (prev && !select_out) falls++;
            prev = select_out;
            if (falls == n) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: pops an expectation on every scan_done, checks hold in between.
    initial begin
        exp_t        e;
        logic [10:0] last_joy;
        logic        last_pres, last_six, done_prev, sel_prev;
        int          toggles, txn;
        last_joy = '0; last_pres = 1'b0; last_six = 1'b0;
        done_prev = 1'b0; sel_prev = 1'b1; toggles = 0; txn = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_joy = '0; last_pres = 1'b0; last_six = 1'b0;
                done_prev = 1'b0; sel_prev = 1'b1; toggles = 0;
            end else begin
                if (select_out != sel_prev) toggles++;
                sel_prev = select_out;
                if (scan_done) begin
                    txn++;
                    check("scan_done_width", {31'b0, done_prev}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_scan_done: got scan %0d, expected none", txn);
                    end else begin
                        e = exp_q.pop_front();
                        $display("scan %0d: joy=%b present=%b six=%b (want joy=%b present=%b six=%b)",
                                 txn, joy_out, pad_present, six_button, e.joy, e.pres, e.six);
                        check("joy_out", {21'b0, joy_out}, {21'b0, e.joy});
                        check("pad_present", {31'b0, pad_present}, {31'b0, e.pres});
                        check("six_button", {31'b0, six_button}, {31'b0, e.six});
                    end
                    check("select_toggles", toggles, 8);
                    toggles   = 0;
                    last_joy  = joy_out;
                    last_pres = pad_present;
                    last_six  = six_button;
                end else begin
                    check("outputs_hold", {19'b0, joy_out, pad_present, six_button},
                          {19'b0, last_joy, last_pres, last_six});
                end
                done_prev = scan_done;
            end
        end
    end

    // Stimulus
    initial begin
        int cyc;
        bit got;
        int sel_lows, dones;

        enable = 1'b1;
        reset  = 1'b1;
        #2 reset = 1'b0;
        set_pad(0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_state", {17'b0, select_out, joy_out, pad_present, six_button, scan_done},
              32'h4000);

        // No pad: first scan and its latency from reset release.
        push_exp();
        reset = 1'b1;
        wait_scan(SCAN + 50, cyc, got);
        check("first_scan_seen", {31'b0, got}, 32'd1);
        check("first_scan_latency", cyc, SCAN);

        // Directed pads, each changed right after a scan_done.
        set_pad(1, 11'b000_0100_1000, 1'b0);          // A + Up
        push_exp();
        wait_scan(SCAN + 50, cyc, got);
        check("scan_seen", {31'b0, got}, 32'd1);
        check("scan_period", cyc, SCAN);

        set_pad(2, 11'b100_0010_0001, 1'b1);          // X + C + Right, MODE pressed
        push_exp();
        wait_scan(SCAN + 50, cyc, got);
        check("scan_seen", {31'b0, got}, 32'd1);
        check("scan_period", cyc, SCAN);

        set_pad(2, '0, 1'b0);                         // released
        push_exp();
        wait_scan(SCAN + 50, cyc, got);
        check("scan_seen", {31'b0, got}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            set_pad(int'($urandom_range(0, 2)), 11'($urandom), 1'($urandom));
            push_exp();
            wait_scan(SCAN + 50, cyc, got);
            check("scan_seen", {31'b0, got}, 32'd1);
            check("scan_period", cyc, SCAN);
        end

        // enable=0 from reset: nothing happens.
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        set_pad(1, 11'($urandom), 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sel_lows = 0;
        dones = 0;
        repeat (500) begin
            @(negedge clk);
            if (!select_out) sel_lows++;
            if (scan_done) dones++;
        end
        check("disabled_select_low", sel_lows, 0);
        check("disabled_scan_done", dones, 0);

        // Drop enable during PH3: the scan still completes, then idle holds.
        enable = 1'b1;
        push_exp();
        wait_fall(2, SCAN, got);
        check("reach_ph3", {31'b0, got}, 32'd1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_scan(SCAN, cyc, got);
        check("scan_after_disable", {31'b0, got}, 32'd1);
        sel_lows = 0;
        dones = 0;
        repeat (300) begin
            @(negedge clk);
            if (!select_out) sel_lows++;
            if (scan_done) dones++;
        end
        check("post_disable_select_low", sel_lows, 0);
        check("post_disable_scan_done", dones, 0);

        // Reset during PH5 with a 6-button pad holding Start.
        set_pad(2, 11'b000_1000_0000, 1'b0);
        enable = 1'b1;
        wait_fall(3, SCAN, got);
        check("reach_ph5", {31'b0, got}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_reset_state", {17'b0, select_out, joy_out, pad_present, six_button, scan_done},
              32'h4000);
        @(negedge clk);
        push_exp();
        reset = 1'b1;
        wait_scan(SCAN + 50, cyc, got);
        check("scan_after_abort", {31'b0, got}, 32'd1);
        check("start_reported", {31'b0, joy_out[7]}, 32'd1);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
